// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencer: block handshake, H init/accumulate pulses,
// round index with K constant and W-source select, digest completion flag.
module sha256_round_ctrl #(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned IDX_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blk_valid,
    input  logic             blk_last,
    input  logic             abort,
    output logic             blk_ready,
    output logic             round_en,
    output logic [IDX_W-1:0] round_idx,
    output logic [31:0]      k_out,
    output logic             w_sel,
    output logic             init_h,
    output logic             accum_h,
    output logic             digest_valid,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] W_MSG_IDX  = IDX_W'(16);

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        ACCUM = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   msg_active;
    logic   last_q;
    logic   accept;
    logic   last_round;

    assign accept     = blk_valid & blk_ready & ~abort;
    assign last_round = (round_idx == LAST_IDX);

    // K constant follows the registered round index with no added latency
    assign k_out = K_TAB[6'(round_idx)];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort returns to IDLE from anywhere
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = msg_active ? ROUND : INIT;
                INIT:    state_nxt = ROUND;
                ROUND:   if (last_round) state_nxt = ACCUM;
                ACCUM:   state_nxt = last_q ? DONE : IDLE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs decoded from state; H/digest pulses suppressed on an abort cycle
    always_comb begin
        blk_ready    = (state == IDLE) & ~rst;
        busy         = (state != IDLE);
        round_en     = (state == ROUND);
        w_sel        = (state == ROUND) & (round_idx < W_MSG_IDX);
        init_h       = (state == INIT)  & ~abort;
        accum_h      = (state == ACCUM) & ~abort;
        digest_valid = (state == DONE)  & ~abort;
    end

    // Round counter: runs only in ROUND, back to 0 on exit or abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_idx <= '0;
        end else if (abort || state != ROUND || last_round) begin
            round_idx <= '0;
        end else begin
            round_idx <= round_idx + IDX_W'(1);
        end
    end

    // Message tracking: set on INIT, cleared on DONE or abort; last flag captured on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_active <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            if (abort || state == DONE) begin
                msg_active <= 1'b0;
            end else if (state == INIT) begin
                msg_active <= 1'b1;
            end
            if (accept) begin
                last_q <= blk_last;
            end
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_sha256_round_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        blk_valid = 1'b0;
    logic        blk_last = 1'b0;
    logic        abort = 1'b0;
    logic        blk_ready;
    logic        round_en;
    logic [5:0]  round_idx;
    logic [31:0] k_out;
    logic        w_sel;
    logic        init_h;
    logic        accum_h;
    logic        digest_valid;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    sha256_round_ctrl #(.ROUNDS(64), .IDX_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .blk_valid    (blk_valid),
        .blk_last     (blk_last),
        .abort        (abort),
        .blk_ready    (blk_ready),
        .round_en     (round_en),
        .round_idx    (round_idx),
        .k_out        (k_out),
        .w_sel        (w_sel),
        .init_h       (init_h),
        .accum_h      (accum_h),
        .digest_valid (digest_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected K values at a few hand-picked indices (FIPS 180-4)
    function automatic logic [31:0] k_ref(input int i);
        case (i)
            0:       return 32'h428a2f98;
            15:      return 32'hc19bf174;
            16:      return 32'he49b69c1;
            30:      return 32'h06ca6351;
            40:      return 32'ha2bfe8a1;
            63:      return 32'hc67178f2;
            default: return 32'h0;
        endcase
    endfunction

    // Runs one block from an IDLE falling edge; returns at the first IDLE falling edge afterwards.
    // hold keeps blk_valid high the whole time and checks that nothing else is accepted.
    task automatic run_block(input bit is_new, input bit last, input bit hold);
        blk_valid = 1'b1;
        blk_last  = last;
        chk("ready_idle", 32'(blk_ready), 32'd1);
        if (is_new) begin
            @(negedge clk);
            if (!hold) blk_valid = 1'b0;
            chk("init_h", 32'(init_h), 32'd1);
            chk("init_round_en", 32'(round_en), 32'd0);
            chk("init_busy", 32'(busy), 32'd1);
            if (hold) chk("init_ready", 32'(blk_ready), 32'd0);
        end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!hold) blk_valid = 1'b0;
            chk("round_en", 32'(round_en), 32'd1);
            chk("round_idx", 32'(round_idx), 32'(i));
            chk("w_sel", 32'(w_sel), (i < 16) ? 32'd1 : 32'd0);
            chk("round_pulses", {29'd0, init_h, accum_h, digest_valid}, 32'd0);
            if (k_ref(i) != 32'h0) chk("k_out", k_out, k_ref(i));
            if (hold) chk("round_ready", 32'(blk_ready), 32'd0);
        end
        @(negedge clk);
        chk("accum_h", 32'(accum_h), 32'd1);
        chk("accum_round_en", 32'(round_en), 32'd0);
        chk("accum_digest", 32'(digest_valid), 32'd0);
        if (hold) chk("accum_ready", 32'(blk_ready), 32'd0);
        if (last) begin
            @(negedge clk);
            chk("digest_valid", 32'(digest_valid), 32'd1);
            chk("digest_accum", 32'(accum_h), 32'd0);
            chk("done_busy", 32'(busy), 32'd1);
            if (hold) chk("done_ready", 32'(blk_ready), 32'd0);
        end
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(blk_ready), 32'd1);
        chk("idle_pulses", {29'd0, init_h, accum_h, digest_valid}, 32'd0);
    endtask

    // Accepts a new single-block message and stops at the falling edge showing round index n
    task automatic run_to_idx(input int n);
        blk_valid = 1'b1;
        blk_last  = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        chk("pre_init_h", 32'(init_h), 32'd1);
        for (int i = 0; i <= n; i++) @(negedge clk);
        chk("reach_idx", 32'(round_idx), 32'(n));
        chk("reach_k", k_out, k_ref(n));
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_ready", 32'(blk_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(round_idx), 32'd0);
        chk("rst_k", k_out, 32'h428a2f98);
        chk("rst_outs", {27'd0, round_en, w_sel, init_h, accum_h, digest_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single-block message
        run_block(1'b1, 1'b1, 1'b0);

        // Two-block message: init only on the first block, digest only at the end
        run_block(1'b1, 1'b0, 1'b0);
        run_block(1'b0, 1'b1, 1'b0);

        // blk_valid held high across a block; next acceptance on first IDLE cycle
        run_block(1'b1, 1'b0, 1'b1);
        run_block(1'b0, 1'b1, 1'b0);

        // Abort at round 30, then a fresh message needs init_h again
        run_to_idx(30);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_round_en", 32'(round_en), 32'd0);
        chk("abort_idx", 32'(round_idx), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_quiet", {29'd0, init_h, accum_h, digest_valid}, 32'd0);
        end
        run_block(1'b1, 1'b1, 1'b0);

        // Asynchronous reset between edges at round 40
        run_to_idx(40);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_round_en", 32'(round_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(blk_ready), 32'd0);
        chk("arst_idx", 32'(round_idx), 32'd0);
        chk("arst_k", k_out, 32'h428a2f98);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("arst_quiet", {29'd0, init_h, accum_h, digest_valid}, 32'd0);
        end
        run_block(1'b1, 1'b1, 1'b0);

        // abort and blk_valid together in IDLE: not accepted; next cycle accepted
        blk_valid = 1'b1;
        blk_last  = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_init", 32'(init_h), 32'd0);
        run_block(1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
